// File: rtl/divider_seq.sv
// Sequential restoring divider: signed or unsigned, one quotient bit per clock.
// Fixed latency of WIDTH+2 edges from accepted start to the done pulse.
module divider_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic            q_neg;
  logic            r_neg;
  logic            zero_dvs;

  logic            dvd_sign;
  logic            dvs_sign;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]  shifted;
  logic [WIDTH:0]  trial;

  always_comb begin
    dvd_sign = is_signed & dividend[WIDTH-1];
    dvs_sign = is_signed & divisor[WIDTH-1];
    dvd_mag  = dvd_sign ? (~dividend + 1'b1) : dividend;
    dvs_mag  = dvs_sign ? (~divisor + 1'b1) : divisor;
    // The partial remainder is widened by one bit so that operands at or
    // above 2^(WIDTH-1) cannot overflow the trial subtraction.
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero_dvs    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rem      <= '0;
            quo      <= dvd_mag;
            dvs      <= dvs_mag;
            q_neg    <= dvd_sign ^ dvs_sign;
            r_neg    <= dvd_sign;
            zero_dvs <= (divisor == '0);
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
          end else begin
            rem <= shifted[WIDTH-1:0];
          end
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          if (cnt == LAST) begin
            state <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          // With a zero divisor the loop leaves |dividend| in rem, so the
          // usual sign fix-up restores the dividend exactly as sampled.
          quotient    <= zero_dvs ? '1 : (q_neg ? (~quo + 1'b1) : quo);
          remainder   <= r_neg ? (~rem + 1'b1) : rem;
          div_by_zero <= zero_dvs;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed, table-driven check of divider_seq at WIDTH=32 plus hand-written
// back-to-back and mid-operation reset sequences.
module tb_divider_seq;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  divider_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: issues one operation, scrambles inputs and pulses
  // start while busy, and returns once done is seen or the budget expires.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic busy_ok);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    lat = -1; busy_ok = 1'b1;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(posedge clk); #1;
      start = (n == 5) || (n == 20);
      dividend = $urandom; divisor = $urandom; is_signed = ~s;
      if (done) begin
        lat = n;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string name, input vec_t v);
    int   lat;
    logic bok;
    run_op(v.sgn, v.a, v.b, lat, bok);
    check({name, "_latency"}, 64'(lat), 64'(LAT));
    check({name, "_busy"},    64'(bok), 64'd1);
    check({name, "_q"},       64'(quotient), 64'(v.q));
    check({name, "_r"},       64'(remainder), 64'(v.r));
    check({name, "_dbz"},     64'(div_by_zero), 64'(v.z));
  endtask

  initial begin
    int   done_cnt;
    int   d1;
    int   d2;
    logic [W-1:0] q_hold;
    logic [W-1:0] r_hold;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    vecs[3]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[5]  = '{1'b1, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'h10,       32'h0FFFFFFF, 32'hF,        1'b0};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'd1,        32'd1,        1'b0};
    vecs[10] = '{1'b0, 32'd5,          32'd9,        32'd0,        32'd5,        1'b0};
    vecs[11] = '{1'b1, 32'hFFFFFFF8,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1};
    vecs[12] = '{1'b0, 32'h80000001,   32'h80000000, 32'd1,        32'd1,        1'b0};
    vecs[13] = '{1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("reset_outputs", {busy, done, quotient, remainder, div_by_zero}, '0);

    // First start lands on the first rising edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i != 0) @(negedge clk);
      check_op($sformatf("vec%0d", i), vecs[i]);
    end

    q_hold = quotient; r_hold = remainder;
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", 64'(quotient), 64'(q_hold));
    check("hold_r", 64'(remainder), 64'(r_hold));
    check("hold_done_low", 64'(done), 64'd0);

    // Abort an operation at CALC edge 10; outputs of the previous op are nonzero.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'h12345678; divisor = 32'd3;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy, done, quotient, remainder, div_by_zero}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < LAT + 8; n++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    @(negedge clk);
    check_op("after_abort", '{1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0});

    // Back-to-back: second start in the done cycle, stray starts while busy.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    done_cnt = 0; d1 = -1; d2 = -1;
    for (int n = 1; n <= 2 * LAT + 12; n++) begin
      @(posedge clk); #1;
      start = (n == 3) || (n == 10) || (n == 40) || (n == 50);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          d1 = n;
          check("b2b_q1", 64'(quotient), 64'd14);
          check("b2b_r1", 64'(remainder), 64'd2);
          start = 1'b1; is_signed = 1'b1; dividend = 32'hFFFFFFF9; divisor = 32'd2;
        end else if (done_cnt == 2) begin
          d2 = n;
          check("b2b_q2", 64'(quotient), 64'hFFFFFFFD);
          check("b2b_r2", 64'(remainder), 64'hFFFFFFFF);
        end
      end else if (done_cnt == 1 && n == d1 + 1) begin
        dividend = $urandom; divisor = $urandom; is_signed = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 64'(done_cnt), 64'd2);
    check("b2b_first_edge", 64'(d1), 64'(LAT));
    check("b2b_spacing", 64'(d2 - d1), 64'(LAT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
